uart_tx_fifo_drain: RTL and testbench
=====================================

// Module: uart_tx_fifo_drain
// PURPOSE
//  Downstream consumer of the TX FIFO controller/register-file pair.
//  Pops one byte whenever the FIFO is non-empty and serialises it as an 8N1 UART frame on tx.
//  Contains its own 16x-oversampling baud tick generator (divisor set by software via dvsr).
//  Sits between the FIFO and the board TX pin in the MicroBlaze UART I/O core.
// PARAMETERS
//  DBIT        8   data bits per frame, LSB first
//  SB_TICK     16  oversample ticks for stop bit (16=1 stop, 24=1.5, 32=2); counter width $clog2(SB_TICK)
//  DVSR_WIDTH  11  width of baud divisor input
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-high
//  dvsr         in   DVSR_WIDTH  baud divisor; tick rate = f_clk/(dvsr+1) = 16x baud
//  fifo_empty   in   1           empty flag from FIFO controller
//  fifo_r_data  in   DBIT        FIFO read-port data, valid while fifo_empty=0
//  fifo_rd      out  1           pop strobe to FIFO controller rd input
//  tx           out  1           serial output, idle high
//  tx_busy      out  1           1 while a frame is in progress
// BEHAVIOUR
//  Reset: state=IDLE, tx=1, fifo_rd=0, tx_busy=0, baud count=0, shift reg=0, bit/tick counters=0.
//  Reset is async: tx forced to 1 immediately, even mid-frame; popped in-flight byte is lost.
//  Baud gen: free-running counter; tick=1 for one clk when count>=dvsr, then count<=0, else count+1.
//   dvsr=0 -> tick every clk. dvsr change takes effect from the current count (no restart).
//  FSM states: IDLE, START, DATA, STOP. s = tick counter, n = bit counter.
//  IDLE: tx=1. fifo_rd = (state==IDLE) & ~fifo_empty, combinational, exactly one cycle;
//   on that edge: shift<=fifo_r_data, s<=0, n<=0, state<=START. No pop in any other state.
//  START: tx=0. On each tick: if s==15 -> s<=0, state<=DATA, else s+1.
//  DATA: tx=shift[0]. On tick with s==15: s<=0, shift>>=1; if n==DBIT-1 -> STOP, else n+1.
//  STOP: tx=1. On tick with s==SB_TICK-1 -> state<=IDLE.
//  Non-tick cycles: counters, shift reg and state hold.
//  tx is registered from next-state/next-shift; it changes on the same edge as the state.
//  Tick phase is free-running, so START lasts 15*(dvsr+1)+1..16*(dvsr+1) clks; every later bit is exactly 16*(dvsr+1) clks.
//  tx_busy = (state!=IDLE), registered with state.
//  Back-to-back: STOP->IDLE, then pop in the first IDLE cycle if non-empty; at most 1 extra clk of idle-high between frames.
//  fifo_empty asserting while busy has no effect. fifo_empty deasserting while busy is ignored until IDLE.
//  fifo_rd is never asserted while fifo_empty=1, so the FIFO never underflows.
// TESTING
//  1 reset with FIFO empty -> tx=1, tx_busy=0, fifo_rd=0; hold 100 clks, no change.
//  2 dvsr=3, push 0x55 -> one fifo_rd pulse; tx=0,1,0,1,0,1,0,1,0,1.
//    Each bit 64 clks, except the start bit at 61..64 clks. tx_busy falls after the stop bit.
//  3 dvsr=0, push 0x00,0xFF,0x81 -> exactly 3 fifo_rd pulses.
//    Frames decode to 00,FF,81; each is 160 clks; inter-frame gap <=1 clk.
//  4 dvsr=0, assert reset at the 5th data bit of 0xA5 -> tx=1 same cycle, tx_busy=0.
//    After release with 0x3C queued: 0x3C is popped and sent intact.
//  5 SB_TICK=32, dvsr=0, byte 0x01 -> stop high 32 clks before next start.
//  6 change dvsr 3->7 while IDLE -> the next frame's bits are 128 clks each.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - pops bytes from the TX FIFO and sends them as 8N1 UART frames
// Includes a 16x-oversampling baud tick generator driven by a software divisor.
module uart_tx_fifo_drain #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DBIT-1:0]       fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int SW = $clog2(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_LAST  = SW'(15);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_next;
  logic [DVSR_WIDTH-1:0] count;
  logic                  tick;
  logic [SW-1:0]         s, s_next;
  logic [NW-1:0]         n, n_next;
  logic [DBIT-1:0]       shift, shift_next;
  logic                  tx_next;

  // Free-running: a divisor change applies from the current count, no restart.
  assign tick = (count >= dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      s       <= s_next;
      n       <= n_next;
      shift   <= shift_next;
      tx      <= tx_next;
      tx_busy <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shift_next = shift;
    fifo_rd    = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset so a queued byte is not popped and lost.
        if (!fifo_empty && !reset) begin
          fifo_rd    = 1'b1;
          shift_next = fifo_r_data;
          s_next     = '0;
          n_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next     = '0;
            shift_next = shift >> 1;
            if (n == N_LAST)
              state_next = STOP;
            else
              n_next = n + 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s == SB_LAST) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx follows the next state so it changes on the same edge as the state.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - self-checking bench for uart_tx_fifo_drain
// Two instances (1 and 2 stop bits) are compared against an arithmetic frame-timing model.
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

  localparam int MAXE = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] dvsr = '0;
  logic        empty_a, empty_b;
  logic [7:0]  data_a, data_b;
  logic        rd_a, rd_b, tx_a, tx_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR_WIDTH(11)) dut_a (
    .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(empty_a), .fifo_r_data(data_a),
    .fifo_rd(rd_a), .tx(tx_a), .tx_busy(busy_a)
  );

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR_WIDTH(11)) dut_b (
    .clk(clk), .reset(reset), .dvsr(dvsr), .fifo_empty(empty_b), .fifo_r_data(data_b),
    .fifo_rd(rd_b), .tx(tx_b), .tx_busy(busy_b)
  );

  typedef struct {
    int          dv;
    int          nb;
    logic [31:0] bytes;
    int          exp_pops;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] q_a[$], q_b[$];
  bit         s_tx[2][MAXE], s_busy[2][MAXE], s_rd[2][MAXE];
  bit         e_tx[2][MAXE], e_busy[2][MAXE], e_rd[2][MAXE];
  int         pops[2], viol[2];
  int         k;
  int         errors = 0;
  int         checks = 0;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic refresh();
    empty_a = (q_a.size() == 0);
    data_a  = empty_a ? 8'h00 : q_a[0];
    empty_b = (q_b.size() == 0);
    data_b  = empty_b ? 8'h00 : q_b[0];
  endtask

  task automatic push(logic [7:0] b);
    q_a.push_back(b);
    q_b.push_back(b);
    refresh();
  endtask

  task automatic sample(int idx);
    s_tx[0][idx] = tx_a; s_busy[0][idx] = busy_a; s_rd[0][idx] = rd_a;
    s_tx[1][idx] = tx_b; s_busy[1][idx] = busy_b; s_rd[1][idx] = rd_b;
    if (rd_a && empty_a) viol[0]++;
    if (rd_b && empty_b) viol[1]++;
  endtask

  // One clock: the FIFO model pops on the edge where the DUT's pop strobe was high.
  task automatic step();
    bit pa, pb;
    pa = rd_a && !reset;
    pb = rd_b && !reset;
    @(posedge clk);
    #1;
    if (pa && q_a.size() > 0) begin void'(q_a.pop_front()); pops[0]++; end
    if (pb && q_b.size() > 0) begin void'(q_b.pop_front()); pops[1]++; end
    refresh();
    k++;
    sample(k);
  endtask

  // Reference frame timing. Edge 1 is the first edge after reset release; the baud
  // tick lands on edges that are multiples of (d+1). A frame popped on edge p spends
  // 16 ticks per start/data symbol and sb ticks in stop, then the next pop is one edge later.
  task automatic build(int di, int d, int sb, int nb, logic [31:0] bytes, output int last);
    int         p, m1, e0, e1;
    logic [7:0] b;
    for (int i = 0; i < MAXE; i++) begin
      e_tx[di][i] = 1'b1; e_busy[di][i] = 1'b0; e_rd[di][i] = 1'b0;
    end
    p  = 1;
    e1 = 0;
    for (int f = 0; f < nb; f++) begin
      b = bytes[8*f +: 8];
      e_rd[di][p-1] = 1'b1;
      m1 = (p / (d + 1) + 1) * (d + 1);
      for (int j = 0; j < 10; j++) begin
        e0 = (j == 0) ? p : m1 + (16 * j - 1) * (d + 1);
        e1 = m1 + ((j == 9) ? (16 * 9 + sb - 1) : (16 * (j + 1) - 1)) * (d + 1);
        for (int t = e0; t < e1 && t < MAXE; t++) begin
          e_busy[di][t] = 1'b1;
          e_tx[di][t]   = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
        end
      end
      p = e1 + 1;
    end
    last = e1;
  endtask

  task automatic cmp_wave(int vi, int di, int which, string nm, int n);
    int bad;
    bit ba, be;
    bad = -1; ba = 1'b0; be = 1'b0;
    for (int i = 0; i <= n; i++) begin
      bit a, e;
      case (which)
        0:       begin a = s_tx[di][i];   e = e_tx[di][i];   end
        1:       begin a = s_busy[di][i]; e = e_busy[di][i]; end
        default: begin a = s_rd[di][i];   e = e_rd[di][i];   end
      endcase
      if (a != e && bad < 0) begin bad = i; ba = a; be = e; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL vec%0d dut%0d %s at edge %0d: got %0b expected %0b", vi, di, nm, bad, ba, be);
    end
  endtask

  // Expects reset asserted on entry; preloads the FIFO, releases reset, records and compares.
  task automatic run_vec(int vi, int d, int nb, logic [31:0] bytes, int exp_pops);
    int la, lb, n;
    reset = 1'b1;
    dvsr  = 11'(d);
    q_a.delete(); q_b.delete();
    for (int f = 0; f < nb; f++) push(bytes[8*f +: 8]);
    refresh();
    pops[0] = 0; pops[1] = 0; viol[0] = 0; viol[1] = 0;
    @(negedge clk);
    check($sformatf("vec%0d reset_state_a", vi), int'({tx_a, busy_a, rd_a}), 4);
    check($sformatf("vec%0d reset_state_b", vi), int'({tx_b, busy_b, rd_b}), 4);
    reset = 1'b0;
    #1;
    k = 0;
    sample(0);
    build(0, d, 16, nb, bytes, la);
    build(1, d, 32, nb, bytes, lb);
    n = ((la > lb) ? la : lb) + 10;
    if (n > MAXE - 1) n = MAXE - 1;
    while (k < n) step();
    for (int di = 0; di < 2; di++) begin
      cmp_wave(vi, di, 0, "tx", n);
      cmp_wave(vi, di, 1, "tx_busy", n);
      cmp_wave(vi, di, 2, "fifo_rd", n);
      check($sformatf("vec%0d dut%0d pops", vi, di), pops[di], exp_pops);
      check($sformatf("vec%0d dut%0d underflow", vi, di), viol[di], 0);
    end
  endtask

  initial begin
    int changes, kstart, i, st, len;
    bit val;

    vecs[0] = '{dv: 3, nb: 1, bytes: 32'h0000_0055, exp_pops: 1};
    vecs[1] = '{dv: 0, nb: 3, bytes: 32'h0081_FF00, exp_pops: 3};
    vecs[2] = '{dv: 0, nb: 1, bytes: 32'h0000_0001, exp_pops: 1};
    for (int v = 3; v < 9; v++) begin
      vecs[v].dv       = int'($urandom_range(0, 3));
      vecs[v].nb       = int'($urandom_range(1, 4));
      vecs[v].bytes    = $urandom;
      vecs[v].exp_pops = vecs[v].nb;
    end
    refresh();

    // Reset with an empty FIFO, then 100 idle clocks with no activity.
    reset = 1'b1;
    #12;
    check("idle reset_state_a", int'({tx_a, busy_a, rd_a}), 4);
    check("idle reset_state_b", int'({tx_b, busy_b, rd_b}), 4);
    @(negedge clk);
    reset = 1'b0;
    changes = 0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if ({tx_a, busy_a, rd_a} != 3'b100 || {tx_b, busy_b, rd_b} != 3'b100) changes++;
    end
    check("idle_100_no_change", changes, 0);

    for (int v = 0; v < 9; v++)
      run_vec(v, vecs[v].dv, vecs[v].nb, vecs[v].bytes, vecs[v].exp_pops);

    // Async reset during data bit 4 of 0xA5; the in-flight byte is lost, 0x3C follows intact.
    reset = 1'b1;
    dvsr  = 11'd0;
    q_a.delete(); q_b.delete();
    push(8'hA5);
    @(negedge clk);
    reset = 1'b0;
    #1;
    k = 0;
    sample(0);
    while (k < 85) step();
    check("a5_bit4_before_reset", int'(tx_a), 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_a", int'({tx_a, busy_a}), 2);
    check("async_reset_b", int'({tx_b, busy_b}), 2);
    run_vec(9, 0, 1, 32'h0000_003C, 1);

    // Divisor 3 -> 7 while idle: the next frame's bits last 128 clocks.
    run_vec(10, 3, 1, 32'h0000_00F0, 1);
    dvsr = 11'd7;
    pops[0] = 0;
    push(8'h55);
    kstart = k;
    for (int c = 0; c < 1400; c++) step();
    check("dvsr7 pops", pops[0], 1);
    i = kstart;
    while (i < k && s_tx[0][i]) i++;
    st = i;
    while (i < k && !s_tx[0][i]) i++;
    check("dvsr7 start_len_in_range", int'((i - st) >= 121 && (i - st) <= 128), 1);
    for (int b = 0; b < 8; b++) begin
      st  = i;
      val = s_tx[0][i];
      while (i < k && s_tx[0][i] == val) i++;
      len = i - st;
      check($sformatf("dvsr7 bit%0d_len", b), len, 128);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
